// File: rtl/pmem_arbiter.sv
// Arbitrates I-cache and D-cache line traffic onto a single 256-bit pmem port.
// Define PMEM_ARB_RR_EN for round-robin tie-breaking; default is fixed D-over-I priority.
module pmem_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned LINE_W = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_address,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    typedef enum logic [1:0] {
        IDLE,
        SERVE_I,
        SERVE_D,
        RELEASE
    } state_t;

    state_t            state_q, state_d;
    logic              last_d_q;
    logic [ADDR_W-1:0] addr_q;
    logic [LINE_W-1:0] wdata_q;
    logic              write_q;
    logic              d_req, d_wins, grant_i, grant_d;

    assign i_rdata      = pmem_rdata;
    assign d_rdata      = pmem_rdata;
    assign pmem_address = addr_q;
    assign pmem_wdata   = wdata_q;

    always_comb begin
        d_req      = d_read | d_write;
`ifdef PMEM_ARB_RR_EN
        d_wins     = ~last_d_q;
`else
        d_wins     = 1'b1;
`endif
        state_d    = state_q;
        grant_i    = 1'b0;
        grant_d    = 1'b0;
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
        i_resp     = 1'b0;
        d_resp     = 1'b0;
        case (state_q)
            IDLE: begin
                if (d_req && (!i_read || d_wins)) begin
                    grant_d = 1'b1;
                    state_d = SERVE_D;
                end else if (i_read) begin
                    grant_i = 1'b1;
                    state_d = SERVE_I;
                end
            end
            SERVE_I: begin
                pmem_read = 1'b1;
                if (pmem_resp) begin
                    // a response racing a reset assertion must not reach the requester
                    i_resp  = rst_n;
                    state_d = RELEASE;
                end
            end
            SERVE_D: begin
                pmem_read  = ~write_q;
                pmem_write = write_q;
                if (pmem_resp) begin
                    d_resp  = rst_n;
                    state_d = RELEASE;
                end
            end
            RELEASE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            last_d_q <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            write_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_d_q <= grant_d | (last_d_q & ~grant_i);
            if (grant_i) begin
                addr_q  <= i_address;
                write_q <= 1'b0;
            end
            if (grant_d) begin
                // d_read together with d_write resolves to a write-back
                addr_q  <= d_address;
                write_q <= d_write;
                wdata_q <= d_wdata;
            end
        end
    end

endmodule

// File: tb/tb_pmem_arbiter.sv
// Directed self-checking bench for pmem_arbiter; expected grant order follows PMEM_ARB_RR_EN.
module tb_pmem_arbiter;

    logic         clk;
    logic         rst_n;
    logic         i_read;
    logic [31:0]  i_address;
    logic [255:0] i_rdata;
    logic         i_resp;
    logic         d_read;
    logic         d_write;
    logic [31:0]  d_address;
    logic [255:0] d_wdata;
    logic [255:0] d_rdata;
    logic         d_resp;
    logic         pmem_read;
    logic         pmem_write;
    logic [31:0]  pmem_address;
    logic [255:0] pmem_wdata;
    logic [255:0] pmem_rdata;
    logic         pmem_resp;

    int unsigned  tests_run;
    int unsigned  tests_failed;
    logic [255:0] last_rdata;
    logic [255:0] mem [logic [31:0]];

`ifdef PMEM_ARB_RR_EN
    localparam bit          ORD_D [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    localparam logic [31:0] ORD_A [4] = '{32'h4000, 32'h3000, 32'h4040, 32'h3040};
`else
    localparam bit          ORD_D [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    localparam logic [31:0] ORD_A [4] = '{32'h4000, 32'h4040, 32'h4080, 32'h3000};
`endif

    pmem_arbiter #(.ADDR_W(32), .LINE_W(256)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_read      (i_read),
        .i_address   (i_address),
        .i_rdata     (i_rdata),
        .i_resp      (i_resp),
        .d_read      (d_read),
        .d_write     (d_write),
        .d_address   (d_address),
        .d_wdata     (d_wdata),
        .d_rdata     (d_rdata),
        .d_resp      (d_resp),
        .pmem_read   (pmem_read),
        .pmem_write  (pmem_write),
        .pmem_address(pmem_address),
        .pmem_wdata  (pmem_wdata),
        .pmem_rdata  (pmem_rdata),
        .pmem_resp   (pmem_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Serves one pmem transaction of `lat` command cycles; returns in the RELEASE cycle.
    task automatic run_txn(input string tag, input bit exp_d, input bit exp_wr,
                           input logic [31:0] exp_addr, input logic [255:0] exp_wdata,
                           input int lat);
        int n;
        logic [255:0] rd;
        n = 0;
        while (!(pmem_read || pmem_write) && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (n >= 10) begin
            check($sformatf("%s_timeout", tag), 256'(0), 256'(1));
            return;
        end
        // requester inputs change after grant; pmem side must keep latched values
        if (exp_d) begin
            d_address = ~exp_addr;
            d_wdata   = ~d_wdata;
        end else begin
            i_address = ~exp_addr;
        end
        for (int k = 0; k < lat; k++) begin
            if (k == lat - 1) begin
                pmem_resp = 1'b1;
                if (exp_wr) rd = {8{32'hDEADBEEF}};
                else if (mem.exists(exp_addr)) rd = mem[exp_addr];
                else rd = {8{exp_addr}};
                pmem_rdata = rd;
            end
            #1;
            check($sformatf("%s_rd%0d", tag, k), 256'(pmem_read), 256'(!exp_wr));
            check($sformatf("%s_wr%0d", tag, k), 256'(pmem_write), 256'(exp_wr));
            check($sformatf("%s_addr%0d", tag, k), 256'(pmem_address), 256'(exp_addr));
            if (exp_wr) check($sformatf("%s_wdata%0d", tag, k), pmem_wdata, exp_wdata);
            if (k == lat - 1) begin
                check($sformatf("%s_iresp", tag), 256'(i_resp), 256'(!exp_d));
                check($sformatf("%s_dresp", tag), 256'(d_resp), 256'(exp_d));
                if (!exp_wr) begin
                    last_rdata = exp_d ? d_rdata : i_rdata;
                    check($sformatf("%s_rdata", tag), last_rdata, rd);
                end else begin
                    mem[pmem_address] = pmem_wdata;
                end
            end else begin
                check($sformatf("%s_early_resp%0d", tag, k), 256'({i_resp, d_resp}), 256'(0));
            end
            @(negedge clk);
        end
        pmem_resp = 1'b0;
        if (exp_d) begin
            d_read  = 1'b0;
            d_write = 1'b0;
        end else begin
            i_read = 1'b0;
        end
        #1;
        check($sformatf("%s_release_cmd", tag), 256'({pmem_read, pmem_write}), 256'(0));
        check($sformatf("%s_release_resp", tag), 256'({i_resp, d_resp}), 256'(0));
    endtask

    initial begin
        logic [31:0] next_d;
        logic [31:0] next_i;
        tests_run = 0;
        tests_failed = 0;
        last_rdata = '0;
        rst_n = 1'b0;
        i_read = 1'b1;
        i_address = 32'h0000_1000;
        d_read = 1'b0;
        d_write = 1'b0;
        d_address = '0;
        d_wdata = '0;
        pmem_rdata = '0;
        pmem_resp = 1'b0;

        // reset with a pending I request
        repeat (2) @(negedge clk);
        check("rst_cmd", 256'({pmem_read, pmem_write}), 256'(0));
        check("rst_resp", 256'({i_resp, d_resp}), 256'(0));
        check("rst_addr", 256'(pmem_address), 256'(0));
        check("rst_wdata", pmem_wdata, 256'(0));
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_rel_rd", 256'(pmem_read), 256'(1));
        check("rst_rel_addr", 256'(pmem_address), 256'(32'h1000));
        run_txn("i_single", 1'b0, 1'b0, 32'h1000, '0, 5);
        @(negedge clk);
        check("i_single_idle", 256'({pmem_read, i_resp, d_resp}), 256'(0));

        // write-back then readback through the I port
        d_write = 1'b1;
        d_address = 32'h2000;
        d_wdata = {32{8'hA5}};
        run_txn("d_wb", 1'b1, 1'b1, 32'h2000, {32{8'hA5}}, 3);
        @(negedge clk);
        i_read = 1'b1;
        i_address = 32'h2000;
        run_txn("i_rb", 1'b0, 1'b0, 32'h2000, '0, 2);
        check("rb_data", last_rdata, {32{8'hA5}});
        @(negedge clk);

        // simultaneous requests over consecutive transactions
        i_read = 1'b1;
        i_address = 32'h3000;
        d_read = 1'b1;
        d_address = 32'h4000;
        next_d = 32'h4040;
        next_i = 32'h3040;
        for (int t = 0; t < 4; t++) begin
            run_txn($sformatf("tie%0d", t), ORD_D[t], 1'b0, ORD_A[t], '0, 2);
            if (t < 2) begin
                if (ORD_D[t]) begin
                    d_read = 1'b1;
                    d_address = next_d;
                    next_d = next_d + 32'h40;
                end else begin
                    i_read = 1'b1;
                    i_address = next_i;
                    next_i = next_i + 32'h40;
                end
            end
        end
        @(negedge clk);

        // D request arriving mid I service waits for the next IDLE
        i_read = 1'b1;
        i_address = 32'h5000;
        @(negedge clk);
        check("late_i_cmd", 256'(pmem_read), 256'(1));
        @(negedge clk);
        d_read = 1'b1;
        d_address = 32'h6000;
        run_txn("late_i", 1'b0, 1'b0, 32'h5000, '0, 4);
        @(negedge clk);
        check("late_idle", 256'({pmem_read, pmem_write}), 256'(0));
        @(negedge clk);
        check("late_grant_rd", 256'(pmem_read), 256'(1));
        check("late_grant_addr", 256'(pmem_address), 256'(32'h6000));
        run_txn("late_d", 1'b1, 1'b0, 32'h6000, '0, 2);
        @(negedge clk);

        // reset while D waits on memory; late response must be dropped
        d_read = 1'b1;
        d_address = 32'h7000;
        @(negedge clk);
        check("mr_cmd", 256'(pmem_read), 256'(1));
        @(negedge clk);
        rst_n = 1'b0;
        d_read = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        pmem_resp = 1'b1;
        pmem_rdata = {8{32'h1234_5678}};
        #1;
        check("mr_cmd_off", 256'({pmem_read, pmem_write}), 256'(0));
        check("mr_no_resp", 256'({i_resp, d_resp}), 256'(0));
        check("mr_addr", 256'(pmem_address), 256'(0));
        @(negedge clk);
        pmem_resp = 1'b0;
        #1;
        check("mr_stay_idle", 256'({pmem_read, pmem_write, i_resp, d_resp}), 256'(0));

        // d_read with d_write is taken as a write
        @(negedge clk);
        d_read = 1'b1;
        d_write = 1'b1;
        d_address = 32'h8000;
        d_wdata = {32{8'h5A}};
        run_txn("d_both", 1'b1, 1'b1, 32'h8000, {32{8'h5A}}, 2);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
